// File: rtl/wave_cfg_pkg.sv
// Shared constants, field codes, FSM states and write payload for wave_cfg_ctrl.
// Optional readback port is enabled by defining WAVE_CFG_READBACK_EN.
package wave_cfg_pkg;

  localparam int unsigned NCHAN = 8;
  localparam int unsigned W     = 16;
  localparam int unsigned CHW   = $clog2(NCHAN);
  localparam int unsigned FW    = 2;
  localparam int unsigned BUSW  = NCHAN * W;
  localparam int unsigned RCW   = 4;

  localparam logic [FW-1:0] FLD_AMP = 2'd0;
  localparam logic [FW-1:0] FLD_OFS = 2'd1;
  localparam logic [FW-1:0] FLD_PHW = 2'd2;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    WAIT_TICK = 3'd1,
    APPLY     = 3'd2,
    PHASE_RST = 3'd3,
    DONE      = 3'd4
  } state_e;

  typedef struct packed {
    logic [CHW-1:0] chan;
    logic [FW-1:0]  field;
    logic [W-1:0]   data;
  } wr_req_t;

  // Field code 3 is reserved; everything else maps to a shadow word.
  function automatic logic fld_legal(input logic [FW-1:0] f);
    return (f == FLD_AMP) || (f == FLD_OFS) || (f == FLD_PHW);
  endfunction

endpackage

// File: rtl/wave_cfg_ctrl_if.sv
// Host / datapath bundle for wave_cfg_ctrl; readback signals exist only
// when WAVE_CFG_READBACK_EN is defined.
interface wave_cfg_ctrl_if;
  import wave_cfg_pkg::*;

  logic            wr_valid;
  logic            wr_ready;
  logic [CHW-1:0]  wr_chan;
  logic [FW-1:0]   wr_field;
  logic [W-1:0]    wr_data;
  logic            cmd_commit;
  logic            cmd_sync;
  logic            sync_tick;
  logic            busy;
  logic            commit_done;
  logic            err;
  logic [BUSW-1:0] amps;
  logic [BUSW-1:0] offsets;
  logic [BUSW-1:0] phasewords;
  logic            dp_reset;
`ifdef WAVE_CFG_READBACK_EN
  logic [CHW-1:0]  rd_chan;
  logic [FW-1:0]   rd_field;
  logic [W-1:0]    rd_data;
`endif

  modport master (
`ifdef WAVE_CFG_READBACK_EN
    output rd_chan, output rd_field, input rd_data,
`endif
    output wr_valid, output wr_chan, output wr_field, output wr_data,
    output cmd_commit, output cmd_sync, output sync_tick,
    input  wr_ready, input busy, input commit_done, input err,
    input  amps, input offsets, input phasewords, input dp_reset
  );

  modport slave (
`ifdef WAVE_CFG_READBACK_EN
    input rd_chan, input rd_field, output rd_data,
`endif
    input  wr_valid, input wr_chan, input wr_field, input wr_data,
    input  cmd_commit, input cmd_sync, input sync_tick,
    output wr_ready, output busy, output commit_done, output err,
    output amps, output offsets, output phasewords, output dp_reset
  );

endinterface

// File: rtl/wave_cfg_ctrl_shadow_bank.sv
// Shadow register file (amp/offset/phaseword x NCHAN) with one write port and
// flat parallel outputs; registered readback when WAVE_CFG_READBACK_EN is defined.
module cfg_shadow_bank
  import wave_cfg_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic            i_wr_en,
  input  wr_req_t         i_wr_req,
`ifdef WAVE_CFG_READBACK_EN
  input  logic [CHW-1:0]  i_rd_chan,
  input  logic [FW-1:0]   i_rd_field,
  output logic [W-1:0]    o_rd_data,
`endif
  output logic [BUSW-1:0] o_amps,
  output logic [BUSW-1:0] o_offsets,
  output logic [BUSW-1:0] o_phws
);

  logic [NCHAN-1:0][W-1:0] r_amp;
  logic [NCHAN-1:0][W-1:0] r_ofs;
  logic [NCHAN-1:0][W-1:0] r_phw;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_amp <= '0;
      r_ofs <= '0;
      r_phw <= '0;
    end else if (i_wr_en) begin
      case (i_wr_req.field)
        FLD_AMP: r_amp[i_wr_req.chan] <= i_wr_req.data;
        FLD_OFS: r_ofs[i_wr_req.chan] <= i_wr_req.data;
        FLD_PHW: r_phw[i_wr_req.chan] <= i_wr_req.data;
        default: ;
      endcase
    end
  end

  assign o_amps    = r_amp;
  assign o_offsets = r_ofs;
  assign o_phws    = r_phw;

`ifdef WAVE_CFG_READBACK_EN
  logic [W-1:0] r_rd_data;

  // Reserved field code reads as zero.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rd_data <= '0;
    end else begin
      case (i_rd_field)
        FLD_AMP: r_rd_data <= r_amp[i_rd_chan];
        FLD_OFS: r_rd_data <= r_ofs[i_rd_chan];
        FLD_PHW: r_rd_data <= r_phw[i_rd_chan];
        default: r_rd_data <= '0;
      endcase
    end
  end

  assign o_rd_data = r_rd_data;
`endif

endmodule

// File: rtl/wave_cfg_ctrl.sv
// Commit controller: host writes a shadow bank, a commit copies all channels to the
// active buses atomically on a sync tick (or timeout), optionally pulsing dp_reset.
// Optional shadow readback: define WAVE_CFG_READBACK_EN.
module wave_cfg_ctrl
  import wave_cfg_pkg::*;
#(
  parameter int unsigned RST_CYCLES   = 2,
  parameter int unsigned TICK_TIMEOUT = 1024
) (
  input  logic            clk,
  input  logic            reset,
  wave_cfg_ctrl_if.slave  cfg
);

  localparam int unsigned     TOW      = (TICK_TIMEOUT > 1) ? $clog2(TICK_TIMEOUT) : 1;
  localparam logic [TOW-1:0] TO_LAST  = TOW'((TICK_TIMEOUT == 0) ? 32'd0 : TICK_TIMEOUT - 32'd1);
  localparam logic [RCW-1:0] RST_LAST = RCW'(RST_CYCLES - 32'd1);

  state_e          r_state;
  state_e          w_next_state;
  logic [TOW-1:0]  r_to_cnt;
  logic [RCW-1:0]  r_rst_cnt;
  logic            r_sync;

  logic            w_wr_acc;
  logic            w_wr_ill;
  logic            w_commit_drop;
  logic            w_load;
  logic            w_timeout;

  logic            r_wr_ready;
  logic            r_busy;
  logic            r_done;
  logic            r_err;
  logic            r_dp_reset;

  logic [BUSW-1:0] w_sh_amps;
  logic [BUSW-1:0] w_sh_offsets;
  logic [BUSW-1:0] w_sh_phws;
  logic [BUSW-1:0] r_amps;
  logic [BUSW-1:0] r_offsets;
  logic [BUSW-1:0] r_phws;

  wr_req_t         w_req;

  assign w_req     = '{chan: cfg.wr_chan, field: cfg.wr_field, data: cfg.wr_data};
  assign w_timeout = (TICK_TIMEOUT != 0) && (r_to_cnt == TO_LAST);

  cfg_shadow_bank u_shadow (
    .clk        (clk),
    .reset      (reset),
    .i_wr_en    (w_wr_acc),
    .i_wr_req   (w_req),
`ifdef WAVE_CFG_READBACK_EN
    .i_rd_chan  (cfg.rd_chan),
    .i_rd_field (cfg.rd_field),
    .o_rd_data  (cfg.rd_data),
`endif
    .o_amps     (w_sh_amps),
    .o_offsets  (w_sh_offsets),
    .o_phws     (w_sh_phws)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state and per-cycle strobes; writes are only taken while IDLE.
  always_comb begin
    w_next_state  = r_state;
    w_wr_acc      = 1'b0;
    w_wr_ill      = 1'b0;
    w_commit_drop = 1'b0;
    w_load        = 1'b0;
    case (r_state)
      IDLE: begin
        w_wr_acc = cfg.wr_valid && fld_legal(cfg.wr_field);
        w_wr_ill = cfg.wr_valid && !fld_legal(cfg.wr_field);
        if (cfg.cmd_commit) begin
          w_next_state = WAIT_TICK;
        end
      end
      WAIT_TICK: begin
        w_commit_drop = cfg.cmd_commit;
        if (cfg.sync_tick || w_timeout) begin
          w_next_state = APPLY;
          w_load       = 1'b1;
        end
      end
      APPLY: begin
        w_commit_drop = cfg.cmd_commit;
        w_next_state  = r_sync ? PHASE_RST : DONE;
      end
      PHASE_RST: begin
        w_commit_drop = cfg.cmd_commit;
        if (r_rst_cnt == RST_LAST) begin
          w_next_state = DONE;
        end
      end
      DONE: begin
        w_commit_drop = cfg.cmd_commit;
        w_next_state  = IDLE;
      end
      default: begin
        w_next_state = IDLE;
      end
    endcase
  end

  // Status outputs track the state being entered so they align with it.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ready <= 1'b1;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
      r_dp_reset <= 1'b0;
    end else begin
      r_wr_ready <= (w_next_state == IDLE);
      r_busy     <= (w_next_state != IDLE);
      r_done     <= (w_next_state == DONE);
      r_err      <= w_wr_ill || w_commit_drop;
      r_dp_reset <= (w_next_state == PHASE_RST);
    end
  end

  // Counters sit at zero outside their state, so they start clean on entry.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_to_cnt  <= '0;
      r_rst_cnt <= '0;
      r_sync    <= 1'b0;
    end else begin
      r_to_cnt  <= (r_state == WAIT_TICK) ? r_to_cnt + 1'b1 : '0;
      r_rst_cnt <= (r_state == PHASE_RST) ? r_rst_cnt + 1'b1 : '0;
      if ((r_state == IDLE) && cfg.cmd_commit) begin
        r_sync <= cfg.cmd_sync;
      end
    end
  end

  // Active buses load together on the edge entering APPLY.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_amps    <= '0;
      r_offsets <= '0;
      r_phws    <= '0;
    end else if (w_load) begin
      r_amps    <= w_sh_amps;
      r_offsets <= w_sh_offsets;
      r_phws    <= w_sh_phws;
    end
  end

  assign cfg.wr_ready    = r_wr_ready;
  assign cfg.busy        = r_busy;
  assign cfg.commit_done = r_done;
  assign cfg.err         = r_err;
  assign cfg.dp_reset    = r_dp_reset;
  assign cfg.amps        = r_amps;
  assign cfg.offsets     = r_offsets;
  assign cfg.phasewords  = r_phws;

endmodule

// File: tb/tb_wave_cfg_ctrl.sv
// Self-checking bench for wave_cfg_ctrl: directed scenarios plus random traffic,
// compared every cycle against a cycle-indexed behavioural model.
module tb_wave_cfg_ctrl;

  localparam int R  = 2;
  localparam int TO = 16;
  localparam int INF = 32'h7fff_ffff;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  wave_cfg_ctrl_if cfg();

  wave_cfg_ctrl #(.RST_CYCLES(R), .TICK_TIMEOUT(TO)) dut (
    .clk   (clk),
    .reset (reset),
    .cfg   (cfg)
  );

  int tests = 0;
  int fails = 0;
  int n = 0;

  // Model: shadow/active words plus the cycle numbers of the commit milestones.
  logic [15:0] sh  [3][8];
  logic [15:0] act [3][8];
  int  c_cycle, busy_until, apply_n, done_at, err_at;
  bit  waiting, sync_l;

  int cnt_done, cnt_dp, cnt_err, last_done_n;

  task automatic chk(input string nm, input logic [127:0] got, input logic [127:0] exp_v);
    tests++;
    if (got !== exp_v) begin
      fails++;
      $display("FAIL %s cycle %0d: got %h expected %h", nm, n, got, exp_v);
    end
  endtask

  function automatic logic [127:0] flat(input int f);
    logic [127:0] v;
    for (int i = 0; i < 8; i++) v[16*i +: 16] = act[f][i];
    return v;
  endfunction

  task automatic model_clear();
    for (int f = 0; f < 3; f++)
      for (int i = 0; i < 8; i++) begin
        sh[f][i]  = 16'h0;
        act[f][i] = 16'h0;
      end
    c_cycle = -100; busy_until = -100; apply_n = -100; done_at = -100; err_at = -100;
    waiting = 1'b0; sync_l = 1'b0;
  endtask

  // Advance the model across the edge at the end of cycle n.
  task automatic model_update(input bit rst, input bit wv, input logic [2:0] ch,
                              input logic [1:0] fld, input logic [15:0] d,
                              input bit cc, input bit cs, input bit tk);
    bit idle;
    if (rst) begin
      model_clear();
      return;
    end
    idle = !((n > c_cycle) && (n <= busy_until));
    if (idle) begin
      if (wv) begin
        if (fld == 2'd3) err_at = n + 1;
        else sh[fld][ch] = d;
      end
      if (cc) begin
        c_cycle = n; busy_until = INF; sync_l = cs; waiting = 1'b1;
      end
    end else begin
      if (cc) err_at = n + 1;
      if (waiting && (tk || (n - c_cycle) == TO)) begin
        waiting = 1'b0;
        apply_n = n + 1;
        for (int f = 0; f < 3; f++)
          for (int i = 0; i < 8; i++) act[f][i] = sh[f][i];
        done_at    = apply_n + 1 + (sync_l ? R : 0);
        busy_until = done_at;
      end
    end
  endtask

  task automatic check_outputs();
    bit busy_e, dp_e;
    busy_e = (n > c_cycle) && (n <= busy_until);
    dp_e   = sync_l && (n >= apply_n + 1) && (n <= apply_n + R);
    chk("busy",        128'(cfg.busy),        128'(busy_e));
    chk("wr_ready",    128'(cfg.wr_ready),    128'(!busy_e));
    chk("dp_reset",    128'(cfg.dp_reset),    128'(dp_e));
    chk("commit_done", 128'(cfg.commit_done), 128'(n == done_at));
    chk("err",         128'(cfg.err),         128'(n == err_at));
    chk("amps",        cfg.amps,              flat(0));
    chk("offsets",     cfg.offsets,           flat(1));
    chk("phasewords",  cfg.phasewords,        flat(2));
    if (cfg.commit_done === 1'b1) begin cnt_done++; last_done_n = n; end
    if (cfg.dp_reset === 1'b1) cnt_dp++;
    if (cfg.err === 1'b1) cnt_err++;
  endtask

  task automatic step(input bit rst, input bit wv, input logic [2:0] ch,
                      input logic [1:0] fld, input logic [15:0] d,
                      input bit cc, input bit cs, input bit tk);
    reset          = rst;
    cfg.wr_valid   = wv;
    cfg.wr_chan    = ch;
    cfg.wr_field   = fld;
    cfg.wr_data    = d;
    cfg.cmd_commit = cc;
    cfg.cmd_sync   = cs;
    cfg.sync_tick  = tk;
    model_update(rst, wv, ch, fld, d, cc, cs, tk);
    @(negedge clk);
    n++;
    check_outputs();
  endtask

  task automatic idle(input int k);
    repeat (k) step(1'b0, 1'b0, 3'd0, 2'd0, 16'h0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic clr_cnt();
    cnt_done = 0; cnt_dp = 0; cnt_err = 0; last_done_n = -1;
  endtask

  initial begin
    int c0;
    model_clear();
    clr_cnt();
    @(negedge clk);
    step(1'b1, 1'b0, 3'd0, 2'd0, 16'h0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 3'd0, 2'd0, 16'h0, 1'b0, 1'b0, 1'b0);
    idle(1);
    chk("rst_wr_ready", 128'(cfg.wr_ready), 128'd1);

    // Amp ch3 commit, tick five cycles after the commit, no phase reset.
    clr_cnt();
    step(1'b0, 1'b1, 3'd3, 2'd0, 16'h1234, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 3'd0, 2'd0, 16'h0, 1'b1, 1'b0, 1'b0);
    idle(4);
    step(1'b0, 1'b0, 3'd0, 2'd0, 16'h0, 1'b0, 1'b0, 1'b1);
    idle(4);
    chk("t1_amps", cfg.amps, 128'h0000_0000_0000_0000_1234_0000_0000_0000);
    chk("t1_phw",  cfg.phasewords, 128'h0);
    chk("t1_done_cnt", 128'(cnt_done), 128'd1);
    chk("t1_dp_cnt",   128'(cnt_dp),   128'd0);

    // Phasewords on all channels, sync commit with an immediate tick.
    clr_cnt();
    for (int i = 0; i < 8; i++)
      step(1'b0, 1'b1, 3'(i), 2'd2, 16'(16'h0100 * (i + 1)), 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 3'd0, 2'd0, 16'h0, 1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b0, 3'd0, 2'd0, 16'h0, 1'b0, 1'b0, 1'b1);
    idle(6);
    chk("t2_phw", cfg.phasewords, 128'h0800_0700_0600_0500_0400_0300_0200_0100);
    chk("t2_dp_cnt",   128'(cnt_dp),   128'd2);
    chk("t2_done_cnt", 128'(cnt_done), 128'd1);

    // No tick: timeout forces APPLY after 16 waiting cycles.
    clr_cnt();
    c0 = n;
    step(1'b0, 1'b0, 3'd0, 2'd0, 16'h0, 1'b1, 1'b0, 1'b0);
    idle(24);
    chk("t3_done_latency", 128'(last_done_n - c0), 128'd18);

    // Second commit while waiting is dropped; held write stalls until IDLE.
    clr_cnt();
    step(1'b0, 1'b0, 3'd0, 2'd0, 16'h0, 1'b1, 1'b0, 1'b0);
    for (int k = 0; k < 8; k++)
      step(1'b0, 1'b1, 3'd1, 2'd1, 16'hBEEF, k == 0, 1'b0, k == 3);
    idle(3);
    chk("t4_err_cnt",  128'(cnt_err),  128'd1);
    chk("t4_done_cnt", 128'(cnt_done), 128'd1);

    // Illegal field write is discarded; the next commit shows the shadow intact.
    clr_cnt();
    step(1'b0, 1'b1, 3'd0, 2'd3, 16'hFFFF, 1'b0, 1'b0, 1'b0);
    idle(2);
    step(1'b0, 1'b0, 3'd0, 2'd0, 16'h0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 3'd0, 2'd0, 16'h0, 1'b0, 1'b0, 1'b1);
    idle(4);
    chk("t5_err_cnt", 128'(cnt_err), 128'd1);
    chk("t5_amps",    cfg.amps,    128'h0000_0000_0000_0000_1234_0000_0000_0000);
    chk("t5_offsets", cfg.offsets, 128'h0000_0000_0000_0000_0000_0000_BEEF_0000);

    // Reset while dp_reset is asserted.
    step(1'b0, 1'b0, 3'd0, 2'd0, 16'h0, 1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b0, 3'd0, 2'd0, 16'h0, 1'b0, 1'b0, 1'b1);
    idle(1);
    chk("t6_dp_before", 128'(cfg.dp_reset), 128'd1);
    step(1'b1, 1'b0, 3'd0, 2'd0, 16'h0, 1'b0, 1'b0, 1'b0);
    chk("t6_dp",    128'(cfg.dp_reset), 128'd0);
    chk("t6_busy",  128'(cfg.busy),     128'd0);
    chk("t6_amps",  cfg.amps,           128'h0);
    chk("t6_phw",   cfg.phasewords,     128'h0);
    idle(1);
    chk("t6_ready", 128'(cfg.wr_ready), 128'd1);

    // Random traffic against the model.
    for (int k = 0; k < 3000; k++) begin
      step($urandom_range(0, 299) == 0,
           1'($urandom_range(0, 1)),
           3'($urandom_range(0, 7)),
           2'($urandom_range(0, 3)),
           16'($urandom),
           $urandom_range(0, 7) == 0,
           1'($urandom_range(0, 1)),
           $urandom_range(0, 9) == 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
